// File: rtl/spi_loader_pkg.sv
// Shared types and constants for the SPI register loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int DATA_W_DEFAULT = 8;
    localparam int BITS_W         = $clog2(DATA_W_DEFAULT);

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, followed by a one-flop edge detector.
// Latency: level_o follows d_i after STAGES cycles; rise_o/fall_o are combinational on level_o.
// Backpressure: none; free-running sampler.
// Ports: clk, rst (async, active-high), d_i (async input),
//        level_o (synced level), rise_o / fall_o (one-cycle edge strobes).
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // All flops clear to the line's idle level so that releasing reset
    // never manufactures an edge by itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_reg_loader.sv
// SPI mode-0 slave that assembles MSB-first bytes and writes them to the storage register.
// Latency: we rises SYNC_STAGES+1 clk cycles after the 8th sclk high is first sampled.
// Backpressure: none; the master paces everything, clk must be >= 4x sclk.
// Ports: clk, rst (async, active-high); sclk, cs_n, mosi (async SPI inputs), miso (0 when idle);
//        rdata_in (register read-back), we/wdata (write strobe and byte), busy, frame_err.
import spi_loader_pkg::*;

module spi_reg_loader #(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] rdata_in,
    output logic              we,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              frame_err
);

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic cs_rise, cs_fall, cs_lvl;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst(rst), .d_i(sclk),
        .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .d_i(cs_n),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .d_i(mosi),
        .level_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [DATA_W-1:0]  tx_q, tx_d;
    logic               reload_q, reload_d;
    logic               mosi_al_q;
    logic               we_q, we_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               busy_q, busy_d;
    logic               miso_q, miso_d;
    logic               err_q, err_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        reload_d = reload_q;
        we_d     = 1'b0;
        wdata_d  = wdata_q;
        busy_d   = (state_q != IDLE);
        miso_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                reload_d = 1'b0;
                if (cs_fall) begin
                    tx_d    = rdata_in;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                miso_d = tx_q[DATA_W-1];
                // First falling edge after a commit presents the freshly
                // written register value instead of continuing the old byte.
                if (sclk_fall) begin
                    tx_d     = reload_q ? rdata_in : {tx_q[DATA_W-2:0], 1'b0};
                    reload_d = 1'b0;
                end
                if (sclk_rise) begin
                    rx_d  = {rx_q[DATA_W-2:0], mosi_al_q};
                    cnt_d = (cnt_q == LAST_BIT) ? '0 : cnt_q + 1'b1;
                end
                // A completing bit wins over a simultaneous deselect.
                if (sclk_rise && (cnt_q == LAST_BIT)) begin
                    state_d = COMMIT;
                end else if (cs_rise) begin
                    err_d   = (cnt_q != '0);
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            COMMIT: begin
                miso_d   = cs_lvl ? 1'b0 : tx_q[DATA_W-1];
                we_d     = 1'b1;
                wdata_d  = rx_q;
                reload_d = 1'b1;
                state_d  = cs_lvl ? IDLE : SHIFT;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            reload_q  <= 1'b0;
            mosi_al_q <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            miso_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            reload_q  <= reload_d;
            mosi_al_q <= mosi_lvl;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            miso_q    <= miso_d;
            err_q     <= err_d;
        end
    end

    assign we        = we_q;
    assign wdata     = wdata_q;
    assign busy      = busy_q;
    assign miso      = miso_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_spi_reg_loader.sv
module tb_spi_reg_loader;

    localparam int SS2 = 2;
    localparam int SS3 = 3;

    logic clk = 1'b0;
    logic rst, sclk, cs_n, mosi;
    logic miso, we, busy, frame_err;
    logic [7:0] wdata;
    logic miso3, we3, busy3, err3;
    logic [7:0] wdata3;
    logic [7:0] reg_q, reg3_q;
    logic pre_en;
    logic [7:0] pre_val;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_reg_loader #(.DATA_W(8), .SYNC_STAGES(SS2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .rdata_in(reg_q), .we(we), .wdata(wdata), .busy(busy), .frame_err(frame_err)
    );

    spi_reg_loader #(.DATA_W(8), .SYNC_STAGES(SS3)) dut3 (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso3),
        .rdata_in(reg3_q), .we(we3), .wdata(wdata3), .busy(busy3), .frame_err(err3)
    );

    // The storage register the loader writes into.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_q  <= 8'h00;
            reg3_q <= 8'h00;
        end else begin
            if (we) reg_q <= wdata;
            else if (pre_en) reg_q <= pre_val;
            if (we3) reg3_q <= wdata3;
            else if (pre_en) reg3_q <= pre_val;
        end
    end

    // Observation queues filled away from the active edge.
    logic [7:0] wq[$], w3q[$];
    int weq[$], we3q[$], riseq[$];
    int errn, err3n, consec;
    logic we_prev, we3_prev;
    logic [7:0] tx_arr[4];
    logic [7:0] rx_arr[4];

    always @(negedge clk) begin
        if (!rst) begin
            if (we) begin wq.push_back(wdata); weq.push_back(cyc); if (we_prev) consec++; end
            if (we3) begin w3q.push_back(wdata3); we3q.push_back(cyc); if (we3_prev) consec++; end
            if (frame_err) errn++;
            if (err3) err3n++;
            we_prev  = we;
            we3_prev = we3;
        end
    end

    task automatic clear_obs();
        wq.delete(); w3q.delete(); weq.delete(); we3q.delete(); riseq.delete();
        errn = 0; err3n = 0; consec = 0;
    endtask

    task automatic preload(input logic [7:0] v);
        @(negedge clk); pre_en = 1'b1; pre_val = v;
        @(negedge clk); pre_en = 1'b0;
    endtask

    // Master side: mosi changes with sclk low, miso captured at each rising edge.
    task automatic spi_bits(input logic [7:0] b, input int nbits, input bit cs_last,
                            output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            got[7-i] = miso;
            if (nbits == 8 && i == 7) riseq.push_back(cyc + 1);
            if (cs_last && i == nbits - 1) cs_n = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input int nbytes, input int tail_bits, input bit cs_at_last);
        logic [7:0] got;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < nbytes; b++) begin
            spi_bits(tx_arr[b], 8, cs_at_last && (b == nbytes - 1), got);
            rx_arr[b] = got;
        end
        if (tail_bits > 0) spi_bits(tx_arr[nbytes], tail_bits, 1'b0, got);
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; pre_en = 1'b0; pre_val = 8'h00;
        we_prev = 1'b0; we3_prev = 1'b0;
        clear_obs();
        repeat (3) @(negedge clk);
        checks++; if ({we, wdata, miso, busy, frame_err} !== 12'h000) begin failures++;
            $display("FAIL reset_outputs got=%h exp=000", {we, wdata, miso, busy, frame_err}); end
        checks++; if ({we3, wdata3, miso3, busy3, err3} !== 12'h000) begin failures++;
            $display("FAIL reset_outputs3 got=%h exp=000", {we3, wdata3, miso3, busy3, err3}); end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if ({we, busy, frame_err, miso} !== 4'h0) begin failures++;
            $display("FAIL post_reset_idle got=%h exp=0", {we, busy, frame_err, miso}); end
        checks++; if (busy3 !== 1'b0) begin failures++;
            $display("FAIL post_reset_idle3 busy got=%b exp=0", busy3); end
    endtask

    task automatic test_single_byte();
        clear_obs();
        preload(8'h3C);
        tx_arr[0] = 8'hA5;
        run_frame(1, 0, 1'b0);
        checks++; if (wq.size() !== 1) begin failures++;
            $display("FAIL single_we_count got=%0d exp=1", wq.size()); end
        else begin
            checks++; if (wq[0] !== 8'hA5) begin failures++;
                $display("FAIL single_wdata got=%h exp=a5", wq[0]); end
            checks++; if (weq[0] - riseq[0] !== SS2 + 1) begin failures++;
                $display("FAIL single_latency got=%0d exp=%0d", weq[0] - riseq[0], SS2 + 1); end
        end
        checks++; if (w3q.size() !== 1) begin failures++;
            $display("FAIL single_we_count3 got=%0d exp=1", w3q.size()); end
        else begin
            checks++; if (w3q[0] !== 8'hA5) begin failures++;
                $display("FAIL single_wdata3 got=%h exp=a5", w3q[0]); end
            checks++; if (we3q[0] - riseq[0] !== SS3 + 1) begin failures++;
                $display("FAIL single_latency3 got=%0d exp=%0d", we3q[0] - riseq[0], SS3 + 1); end
        end
        checks++; if (rx_arr[0] !== 8'h3C) begin failures++;
            $display("FAIL single_miso got=%h exp=3c", rx_arr[0]); end
        checks++; if (errn !== 0) begin failures++;
            $display("FAIL single_frame_err got=%0d exp=0", errn); end
        checks++; if (busy !== 1'b0 || wdata !== 8'hA5) begin failures++;
            $display("FAIL single_idle_hold busy=%b wdata=%h exp busy=0 wdata=a5", busy, wdata); end
        checks++; if (consec !== 0) begin failures++;
            $display("FAIL single_we_consec got=%0d exp=0", consec); end
    endtask

    task automatic test_burst();
        clear_obs();
        preload(8'h77);
        tx_arr[0] = 8'h12; tx_arr[1] = 8'h34;
        run_frame(2, 0, 1'b0);
        checks++; if (wq.size() !== 2) begin failures++;
            $display("FAIL burst_we_count got=%0d exp=2", wq.size()); end
        else begin
            checks++; if (wq[0] !== 8'h12 || wq[1] !== 8'h34) begin failures++;
                $display("FAIL burst_wdata got=%h,%h exp=12,34", wq[0], wq[1]); end
        end
        checks++; if (rx_arr[0] !== 8'h77) begin failures++;
            $display("FAIL burst_miso0 got=%h exp=77", rx_arr[0]); end
        checks++; if (rx_arr[1] !== 8'h12) begin failures++;
            $display("FAIL burst_miso1 got=%h exp=12", rx_arr[1]); end
        checks++; if (reg_q !== 8'h34) begin failures++;
            $display("FAIL burst_reg got=%h exp=34", reg_q); end
        checks++; if (errn !== 0 || consec !== 0) begin failures++;
            $display("FAIL burst_err_consec err=%0d consec=%0d exp=0,0", errn, consec); end
    endtask

    task automatic test_abort();
        clear_obs();
        tx_arr[0] = 8'($urandom);
        run_frame(0, 5, 1'b0);
        checks++; if (errn !== 1) begin failures++;
            $display("FAIL abort_err got=%0d exp=1", errn); end
        checks++; if (err3n !== 1) begin failures++;
            $display("FAIL abort_err3 got=%0d exp=1", err3n); end
        checks++; if (wq.size() !== 0) begin failures++;
            $display("FAIL abort_we_count got=%0d exp=0", wq.size()); end
        checks++; if (wdata !== 8'h34) begin failures++;
            $display("FAIL abort_wdata_hold got=%h exp=34", wdata); end
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL abort_busy got=%b exp=0", busy); end
    endtask

    task automatic test_boundary();
        clear_obs();
        tx_arr[0] = 8'hFF;
        run_frame(1, 0, 1'b1);
        checks++; if (wq.size() !== 1) begin failures++;
            $display("FAIL boundary_we_count got=%0d exp=1", wq.size()); end
        else begin
            checks++; if (wq[0] !== 8'hFF) begin failures++;
                $display("FAIL boundary_wdata got=%h exp=ff", wq[0]); end
        end
        checks++; if (w3q.size() !== 1) begin failures++;
            $display("FAIL boundary_we_count3 got=%0d exp=1", w3q.size()); end
        checks++; if (errn !== 0 || err3n !== 0) begin failures++;
            $display("FAIL boundary_err got=%0d,%0d exp=0,0", errn, err3n); end
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL boundary_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] got;
        clear_obs();
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        spi_bits(8'hC3, 4, 1'b0, got);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if ({we, wdata, miso, busy, frame_err} !== 12'h000) begin failures++;
            $display("FAIL midreset_outputs got=%h exp=000", {we, wdata, miso, busy, frame_err}); end
        checks++; if ({we3, wdata3, miso3, busy3, err3} !== 12'h000) begin failures++;
            $display("FAIL midreset_outputs3 got=%h exp=000", {we3, wdata3, miso3, busy3, err3}); end
        repeat (3) @(negedge clk);
        cs_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (wq.size() !== 0 || errn !== 0) begin failures++;
            $display("FAIL midreset_partial we=%0d err=%0d exp=0,0", wq.size(), errn); end
        tx_arr[0] = 8'h5A;
        run_frame(1, 0, 1'b0);
        checks++; if (wq.size() !== 1) begin failures++;
            $display("FAIL midreset_we_count got=%0d exp=1", wq.size()); end
        else begin
            checks++; if (wq[0] !== 8'h5A) begin failures++;
                $display("FAIL midreset_wdata got=%h exp=5a", wq[0]); end
        end
        checks++; if (w3q.size() !== 1) begin failures++;
            $display("FAIL midreset_we_count3 got=%0d exp=1", w3q.size()); end
        checks++; if (rx_arr[0] !== 8'h00) begin failures++;
            $display("FAIL midreset_miso got=%h exp=00", rx_arr[0]); end
    endtask

    // Reference: each full byte is written once in order; miso byte 0 is the
    // register before the frame, byte k is byte k-1 of the same frame;
    // a trailing partial byte produces exactly one frame_err and no write.
    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [7:0] pv;
            int n, tail;
            logic [7:0] exp_m;
            clear_obs();
            pv = 8'($urandom);
            preload(pv);
            n = $urandom_range(1, 3);
            tail = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            for (int k = 0; k < 4; k++) tx_arr[k] = 8'($urandom);
            run_frame(n, tail, 1'b0);
            checks++; if (wq.size() !== n || w3q.size() !== n) begin failures++;
                $display("FAIL rand%0d_we_count got=%0d,%0d exp=%0d", it, wq.size(), w3q.size(), n); end
            else begin
                for (int k = 0; k < n; k++) begin
                    exp_m = (k == 0) ? pv : tx_arr[k-1];
                    checks++; if (wq[k] !== tx_arr[k] || w3q[k] !== tx_arr[k]) begin failures++;
                        $display("FAIL rand%0d_wdata%0d got=%h,%h exp=%h", it, k, wq[k], w3q[k], tx_arr[k]); end
                    checks++; if (rx_arr[k] !== exp_m) begin failures++;
                        $display("FAIL rand%0d_miso%0d got=%h exp=%h", it, k, rx_arr[k], exp_m); end
                    checks++; if (weq[k] - riseq[k] !== SS2 + 1 || we3q[k] - riseq[k] !== SS3 + 1) begin
                        failures++;
                        $display("FAIL rand%0d_latency%0d got=%0d,%0d exp=%0d,%0d", it, k,
                                 weq[k] - riseq[k], we3q[k] - riseq[k], SS2 + 1, SS3 + 1); end
                end
            end
            checks++; if (errn !== ((tail != 0) ? 1 : 0)) begin failures++;
                $display("FAIL rand%0d_err got=%0d exp=%0d", it, errn, (tail != 0) ? 1 : 0); end
            checks++; if (wdata !== tx_arr[n-1] || busy !== 1'b0 || consec !== 0) begin failures++;
                $display("FAIL rand%0d_final wdata=%h busy=%b consec=%0d exp=%h,0,0",
                         it, wdata, busy, consec, tx_arr[n-1]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst();
        test_abort();
        test_boundary();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
